// File: rtl/ysyx_041461_exe_mem_buf.sv
// EXE->MEM pipeline buffer: two-entry skid buffer (MAIN drives MEM, SKID absorbs one beat)
// with a registered in_ready so the MEM stall never reaches the EXE ready path combinationally.
module ysyx_041461_exe_mem_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned TRAP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_st_data,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [4:0]        in_rd,
  input  logic              in_wen,
  input  logic [TRAP_W-1:0] in_trap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_st_data,
  output logic [DATA_W-1:0] out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  output logic [TRAP_W-1:0] out_trap,
  output logic [TRAP_W-1:0] mem_trap
);

  localparam int unsigned RD_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] pc;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic              wen;
    logic [TRAP_W-1:0] trap;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;
  beat_t  main_q;
  beat_t  skid_q;
  beat_t  in_beat;
  logic   out_valid_q;
  logic   in_ready_q;
  logic   in_fire;
  logic   out_fire;
  logic   main_ld;
  logic   main_from_skid;
  logic   skid_ld;

  assign in_beat  = {in_alu, in_st_data, in_pc, in_ctrl, in_rd, in_wen, in_trap};
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next state and slot load enables; flush wins over any transfer in the same cycle.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_ld = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            state_d = TWO;
            skid_ld = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d        = ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, handshake flops and payload slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != EMPTY);
      in_ready_q  <= (state_d != TWO);
      if (main_ld) begin
        main_q <= main_from_skid ? skid_q : in_beat;
      end
      if (skid_ld) begin
        skid_q <= in_beat;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_alu     = main_q.alu;
  assign out_st_data = main_q.st_data;
  assign out_pc      = main_q.pc;
  assign out_ctrl    = main_q.ctrl;
  assign out_rd      = main_q.rd;
  assign out_wen     = main_q.wen;
  assign out_trap    = main_q.trap;

  // Only a trap sitting in MAIN is reported back to EXE.
  assign mem_trap = out_valid_q ? main_q.trap : TRAP_W'(0);

endmodule

// File: tb/tb_ysyx_041461_exe_mem_buf.sv
// Self-checking bench for ysyx_041461_exe_mem_buf: directed scenarios plus a random stream,
// with a FIFO scoreboard of expected beats checked whenever MEM consumes MAIN.
module tb_ysyx_041461_exe_mem_buf;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 5;
  localparam int unsigned TRAP_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] pc;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rd;
    logic              wen;
    logic [TRAP_W-1:0] trap;
  } tb_beat_t;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_st_data;
  logic [DATA_W-1:0] in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        in_rd;
  logic              in_wen;
  logic [TRAP_W-1:0] in_trap;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_st_data;
  logic [DATA_W-1:0] out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [4:0]        out_rd;
  logic              out_wen;
  logic [TRAP_W-1:0] out_trap;
  logic [TRAP_W-1:0] mem_trap;

  int       n_checks = 0;
  int       n_errors = 0;
  bit       mon_en   = 1'b0;
  tb_beat_t sb[$];

  ysyx_041461_exe_mem_buf #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .TRAP_W(TRAP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_st_data(in_st_data), .in_pc(in_pc),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_wen(in_wen), .in_trap(in_trap),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_st_data(out_st_data), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_wen(out_wen), .out_trap(out_trap),
    .mem_trap(mem_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Side fields are derived from alu so every field of a beat is distinct and traceable.
  function automatic tb_beat_t make_beat(input logic [DATA_W-1:0] alu, input logic [TRAP_W-1:0] trap);
    tb_beat_t b;
    b.alu     = alu;
    b.st_data = alu ^ 64'hA5A5_5A5A_F0F0_0F0F;
    b.pc      = 64'h8000_0000 + (alu << 2);
    b.ctrl    = alu[4:0] ^ 5'h15;
    b.rd      = 5'(alu[4:0] + 5'd7);
    b.wen     = ~alu[0];
    b.trap    = trap;
    return b;
  endfunction

  task automatic drive(input logic v, input logic [DATA_W-1:0] alu, input logic [TRAP_W-1:0] trap);
    tb_beat_t b;
    b          = make_beat(alu, trap);
    in_valid   = v;
    in_alu     = b.alu;
    in_st_data = b.st_data;
    in_pc      = b.pc;
    in_ctrl    = b.ctrl;
    in_rd      = b.rd;
    in_wen     = b.wen;
    in_trap    = b.trap;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor at the falling edge: occupancy model, consume check, then queue update for the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      tb_beat_t exp_b;
      tb_beat_t got_b;
      check("occ_out_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("occ_in_ready", 64'(in_ready), 64'(sb.size() < 2));
      if (out_valid && sb.size() != 0)
        check("mem_trap_head", 64'(mem_trap), 64'(sb[0].trap));
      else if (!out_valid)
        check("mem_trap_idle", 64'(mem_trap), 64'(0));
      if (rst_n && !flush) begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 64'(1), 64'(0));
          end else begin
            exp_b = sb.pop_front();
            got_b = {out_alu, out_st_data, out_pc, out_ctrl, out_rd, out_wen, out_trap};
            check("sb_alu", out_alu, exp_b.alu);
            check("sb_st_data", out_st_data, exp_b.st_data);
            check("sb_pc", out_pc, exp_b.pc);
            check("sb_side", 64'({got_b.ctrl, got_b.rd, got_b.wen, got_b.trap}),
                  64'({exp_b.ctrl, exp_b.rd, exp_b.wen, exp_b.trap}));
          end
        end
        if (in_valid && in_ready)
          sb.push_back(make_beat(in_alu, in_trap));
      end else begin
        sb.delete();
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 64'h0, 4'h0);

    // Reset
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_mem_trap", 64'(mem_trap), 64'(0));
    check("rst_out_alu", out_alu, 64'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Streaming at full rate
    out_ready = 1'b1;
    drive(1'b1, 64'h10, 4'h0);
    tick();
    check("stream_alu0", out_alu, 64'h10);
    drive(1'b1, 64'h20, 4'h0);
    tick();
    check("stream_alu1", out_alu, 64'h20);
    check("stream_ready", 64'(in_ready), 64'(1));
    drive(1'b1, 64'h30, 4'h0);
    tick();
    check("stream_alu2", out_alu, 64'h30);
    drive(1'b0, 64'h0, 4'h0);
    tick();
    check("stream_drained", 64'(out_valid), 64'(0));

    // Stall into the skid slot, then release
    out_ready = 1'b0;
    drive(1'b1, 64'hA, 4'h0);
    tick();
    drive(1'b1, 64'hB, 4'h0);
    tick();
    check("skid_full_ready", 64'(in_ready), 64'(0));
    check("skid_head", out_alu, 64'hA);
    drive(1'b1, 64'hC, 4'h0);
    tick();
    check("skid_hold_ready", 64'(in_ready), 64'(0));
    check("skid_hold_alu", out_alu, 64'hA);
    out_ready = 1'b1;
    tick();
    check("skid_rel_b", out_alu, 64'hB);
    check("skid_rel_ready", 64'(in_ready), 64'(1));
    tick();
    check("skid_rel_c", out_alu, 64'hC);
    drive(1'b0, 64'h0, 4'h0);
    tick();
    check("skid_drained", 64'(out_valid), 64'(0));

    // Simultaneous accept and consume in ONE
    out_ready = 1'b0;
    drive(1'b1, 64'h1, 4'h0);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 64'h2, 4'h0);
    tick();
    check("simul_alu", out_alu, 64'h2);
    check("simul_valid", 64'(out_valid), 64'(1));
    check("simul_ready", 64'(in_ready), 64'(1));
    drive(1'b0, 64'h0, 4'h0);
    tick();

    // Trap visible only from MAIN
    out_ready = 1'b0;
    drive(1'b1, 64'h50, 4'h3);
    tick();
    drive(1'b0, 64'h0, 4'h0);
    check("trap_held", 64'(mem_trap), 64'h3);
    tick();
    check("trap_stable", 64'(mem_trap), 64'h3);
    check("trap_stable_alu", out_alu, 64'h50);
    out_ready = 1'b1;
    tick();
    check("trap_cleared", 64'(mem_trap), 64'h0);
    out_ready = 1'b0;
    drive(1'b1, 64'h60, 4'h0);
    tick();
    drive(1'b1, 64'h61, 4'h5);
    tick();
    drive(1'b0, 64'h0, 4'h0);
    check("trap_in_skid_hidden", 64'(mem_trap), 64'h0);
    out_ready = 1'b1;
    tick();
    check("trap_moved_main", 64'(mem_trap), 64'h5);
    tick();
    check("trap_drained", 64'(mem_trap), 64'h0);

    // Flush from TWO drops everything, payload left in place
    out_ready = 1'b0;
    drive(1'b1, 64'h70, 4'h0);
    tick();
    drive(1'b1, 64'h71, 4'h0);
    tick();
    flush = 1'b1;
    drive(1'b1, 64'h72, 4'h0);
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 4'h0);
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_ready", 64'(in_ready), 64'(1));
    check("flush_payload_kept", out_alu, 64'h70);
    tick();
    check("flush_dropped", 64'(out_valid), 64'(0));

    // Reset from TWO also zeroes payload
    drive(1'b1, 64'h80, 4'h0);
    tick();
    drive(1'b1, 64'h81, 4'h0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 64'h82, 4'h0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 64'h0, 4'h0);
    check("mrst_valid", 64'(out_valid), 64'(0));
    check("mrst_ready", 64'(in_ready), 64'(1));
    check("mrst_alu", out_alu, 64'h0);
    check("mrst_pc", out_pc, 64'h0);
    tick();

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = 1'($urandom_range(0, 40) == 0);
      drive(1'($urandom_range(0, 1)), 64'(1000 + i), 4'($urandom_range(0, 3) == 0 ? $urandom_range(1, 15) : 0));
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 64'h0, 4'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    tick();
    check("final_sb_empty", 64'(sb.size()), 64'(0));
    check("final_out_valid", 64'(out_valid), 64'(0));

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
